// File: rtl/spimaster_if.sv
// rtl/spimaster_if.sv - stream and SPI pin bundle for spimaster
interface spimaster_if;
  logic       sink_ready;
  logic       sink_valid;
  logic [7:0] sink_data;
  logic       sink_endofpacket;
  logic       source_ready;
  logic       source_valid;
  logic [7:0] source_data;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_nss;

  modport master (
    output sink_ready,
    input  sink_valid, sink_data, sink_endofpacket,
    input  source_ready,
    output source_valid, source_data,
    output spi_sclk, spi_mosi, spi_nss,
    input  spi_miso
  );

  modport slave (
    input  sink_ready,
    output sink_valid, sink_data, sink_endofpacket,
    output source_ready,
    input  source_valid, source_data,
    input  spi_sclk, spi_mosi, spi_nss,
    output spi_miso
  );
endinterface

// File: rtl/spimaster.sv
// rtl/spimaster.sv - byte-oriented mode-0 SPI master with Avalon-ST streams
module spimaster #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input logic         clk_clk,
  input logic         reset_reset_n,
  spimaster_if.master bus
);
  typedef enum logic [2:0] {IDLE, SHIFT, NEXT, TAIL, GAP} state_t;

  localparam logic [7:0] HALF   = 8'(CLK_DIV);
  localparam logic [7:0] GAPLEN = 8'(CS_GAP);

  state_t     state;
  logic [7:0] cnt;
  logic [7:0] tx_sr;
  logic [7:0] rx_sr;
  logic [7:0] src_data;
  logic [2:0] bit_cnt;
  logic [1:0] miso_sync;
  logic       eop;
  logic       sclk;
  logic       nss;
  logic       snk_rdy;
  logic       src_vld;
  logic       src_take;
  logic       snk_take;
  logic       rdy_after;

  assign src_take  = src_vld && bus.source_ready;
  assign snk_take  = bus.sink_valid && snk_rdy;
  // The sink may only reopen when no RX byte will still be pending after this edge
  assign rdy_after = !src_vld || bus.source_ready;

  assign bus.sink_ready   = snk_rdy;
  assign bus.source_valid = src_vld;
  assign bus.source_data  = src_data;
  assign bus.spi_sclk     = sclk;
  assign bus.spi_mosi     = tx_sr[7];
  assign bus.spi_nss      = nss;

  // Two-flop synchronizer bringing MISO into the clk_clk domain
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) miso_sync <= 2'b00;
    else                miso_sync <= {miso_sync[0], bus.spi_miso};
  end

  // Transfer FSM: chip select, SCLK phases, shift registers and stream handshakes
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      tx_sr    <= 8'd0;
      rx_sr    <= 8'd0;
      src_data <= 8'd0;
      bit_cnt  <= 3'd0;
      eop      <= 1'b0;
      sclk     <= 1'b0;
      nss      <= 1'b1;
      snk_rdy  <= 1'b0;
      src_vld  <= 1'b0;
    end else begin
      if (src_take) src_vld <= 1'b0;
      case (state)
        IDLE, NEXT: begin
          if (snk_take) begin
            tx_sr   <= bus.sink_data;
            eop     <= bus.sink_endofpacket;
            nss     <= 1'b0;
            cnt     <= 8'd0;
            bit_cnt <= 3'd0;
            snk_rdy <= 1'b0;
            state   <= SHIFT;
          end else begin
            snk_rdy <= rdy_after;
          end
        end
        SHIFT: begin
          // cnt starts at 0 so the first phase spans one extra cycle after NSS falls
          if (cnt == HALF) begin
            cnt  <= 8'd1;
            sclk <= ~sclk;
            if (!sclk) begin
              rx_sr <= {rx_sr[6:0], miso_sync[1]};
            end else if (bit_cnt == 3'd7) begin
              // MOSI is left on bit 0 of this byte until the next byte loads
              src_data <= rx_sr;
              src_vld  <= 1'b1;
              bit_cnt  <= 3'd0;
              state    <= eop ? TAIL : NEXT;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx_sr   <= {tx_sr[6:0], 1'b0};
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        TAIL: begin
          if (cnt == HALF) begin
            nss   <= 1'b1;
            cnt   <= 8'd1;
            state <= GAP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        GAP: begin
          if (cnt == GAPLEN) begin
            cnt     <= 8'd0;
            snk_rdy <= rdy_after;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
